// File: rtl/oam_dma_controller_pkg.sv
// Shared bus constants and DMA state encoding for the 2A03 sprite DMA.
package oam_dma_controller_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic        RW_READ       = 1'b1;
    localparam logic        RW_WRITE      = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    function automatic logic is_dma_trigger(
        input logic [15:0] addr,
        input logic        rw
    );
        return (addr == DMA_REG_ADDR) && (rw == RW_WRITE);
    endfunction

endpackage

// File: rtl/cpu_cycle_parity.sv
// Even/odd CPU cycle tracker; 0 on the first cycle after reset release.
module cpu_cycle_parity (
    input  logic clock,
    input  logic nreset,
    output logic parity
);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer and CPU bus arbiter ($4014 -> $2004 copy).
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN stall.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
(
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active
);

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] byte_q, byte_d;
    logic       align_req;

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    cpu_cycle_parity u_parity (
        .clock  (clock),
        .nreset (nreset),
        .parity (parity)
    );

    assign align_req = parity;
`else
    assign align_req = 1'b0;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        page_d    = page_q;
        byte_d    = byte_q;
        bus_addr  = cpu_addr;
        bus_rw    = cpu_rw;
        bus_wdata = cpu_wdata;
        unique case (state_q)
            ST_IDLE: begin
                if (is_dma_trigger(cpu_addr, cpu_rw)) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            // Dummy cycles: CPU address stays on the bus, forced to read
            ST_HALT: begin
                bus_rw  = RW_READ;
                state_d = align_req ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                bus_rw  = RW_READ;
                state_d = ST_READ;
            end
            ST_READ: begin
                bus_addr = {page_q, idx_q};
                bus_rw   = RW_READ;
                byte_d   = bus_rdata;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_rw    = RW_WRITE;
                bus_wdata = byte_q;
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_rdy    = (state_q == ST_IDLE);
    assign dma_active = ~cpu_rdy;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a falling-edge memory model.
module tb_oam_dma_controller;

    logic        clock;
    logic        nreset;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        dma_active;

    oam_dma_controller dut (
        .clock      (clock),
        .nreset     (nreset),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdy    (cpu_rdy),
        .bus_addr   (bus_addr),
        .bus_rw     (bus_rw),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .dma_active (dma_active)
    );

    localparam logic [15:0] STALL_ADDR = 16'h8123;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]  mem [0:65535];
    int          checks;
    int          failures;
    int          cyc;
    int          dcnt;
    int          dummy;
    int          badw;
    int          halt_cyc;
    bit          last_w;
    logic [7:0]  wq [$];
    logic [15:0] rq [$];

    always @(negedge clock) begin
        if (!bus_rw) mem[bus_addr] <= bus_wdata;
        bus_rdata <= mem[bus_addr];
    end

    always @(posedge clock or negedge nreset) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (dma_active) begin
            dcnt = dcnt + 1;
            if (dcnt == 1) halt_cyc = cyc;
            if (!bus_rw) begin
                last_w = 1'b1;
                if (bus_addr == 16'h2004) wq.push_back(bus_wdata);
                else badw = badw + 1;
            end else begin
                last_w = 1'b0;
                if (bus_addr == cpu_addr) dummy = dummy + 1;
                else rq.push_back(bus_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        dcnt = 0;
        dummy = 0;
        badw = 0;
        halt_cyc = -1;
        last_w = 1'b0;
        wq.delete();
        rq.delete();
    endtask

    // want_par < 0: trigger now; else wait until HALT lands on that parity
    task automatic trigger(input logic [7:0] pg, input int want_par);
        @(posedge clock); #1;
        if (want_par >= 0) begin
            while (((cyc + 1) & 1) != want_par) begin
                @(posedge clock); #1;
            end
        end
        clear_log();
        cpu_addr  = 16'h4014;
        cpu_rw    = 1'b0;
        cpu_wdata = pg;
        @(negedge clock);
        chk("trig_rdy", cpu_rdy, 1);
        chk("trig_bus", {bus_rw, bus_addr}, {1'b0, 16'h4014});
        @(posedge clock); #1;
        cpu_addr  = STALL_ADDR;
        cpu_rw    = 1'b1;
        cpu_wdata = 8'h00;
        @(negedge clock);
        chk("halt_rdy", cpu_rdy, 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!cpu_rdy && n < 700) begin
            @(negedge clock);
            n++;
        end
        chk("dma_done", cpu_rdy, 1);
    endtask

    task automatic run_len(input logic [7:0] pg, input int want_par);
        int exp_len;
        trigger(pg, want_par);
        wait_done();
`ifdef OAM_DMA_ALIGN_EN
        exp_len = 513 + (halt_cyc & 1);
`else
        exp_len = 513;
`endif
        chk("dma_len", dcnt, exp_len);
        chk("dummy_cycles", dummy, exp_len - 512);
        chk("no_stray_write", badw, 0);
        chk("last_is_write", last_w, 1);
        chk("wr_count", wq.size(), 256);
    endtask

    initial begin
        int errs;
        int n;
        checks   = 0;
        failures = 0;
        nreset   = 1'b0;
        cpu_addr = 16'h1234;
        cpu_rw   = 1'b1;
        cpu_wdata = 8'h77;
        clear_log();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
            mem[16'hFF00 + i] = 8'h3C;
        end
        #12;
        chk("rst_rdy", cpu_rdy, 1);
        chk("rst_active", dma_active, 0);
        chk("rst_bus", {bus_rw, bus_addr, bus_wdata},
            {cpu_rw, cpu_addr, cpu_wdata});
        @(negedge clock);
        nreset = 1'b1;

        // Page 02 copy
        run_len(8'h02, -1);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < wq.size() && wq[i] !== (8'(i) ^ 8'hA5)) errs++;
            if (i < rq.size() && rq[i] !== 16'h0200 + 16'(i)) errs++;
        end
        chk("p02_rd_count", rq.size(), 256);
        chk("p02_data", errs, 0);
        if (wq.size() == 256) begin
            chk("p02_first", wq[0], 8'hA5);
            chk("p02_last", wq[255], 8'h5A);
        end

        // Both HALT parities
        run_len(8'h02, 0);
        run_len(8'h02, 1);

        // Page FF, no carry into page
        run_len(8'hFF, -1);
        errs = 0;
        for (int i = 0; i < wq.size(); i++) if (wq[i] !== 8'h3C) errs++;
        for (int i = 0; i < rq.size(); i++) if (rq[i] == 16'h0000) errs++;
        chk("pff_data", errs, 0);
        if (rq.size() > 0) chk("pff_last_rd", rq[rq.size() - 1], 16'hFFFF);

        // Reset after 100th $2004 write
        trigger(8'h02, -1);
        n = 0;
        while (wq.size() < 100 && n < 400) begin
            @(negedge clock); #1;
            n++;
        end
        chk("rst_mid_at100", wq.size(), 100);
        nreset = 1'b0;
        #1;
        chk("rst_mid_rdy", cpu_rdy, 1);
        chk("rst_mid_active", dma_active, 0);
        chk("rst_mid_bus", {bus_rw, bus_addr}, {cpu_rw, cpu_addr});
        @(negedge clock);
        @(negedge clock);
        nreset = 1'b1;
        repeat (600) @(negedge clock);
        chk("rst_mid_no_more", wq.size(), 100);
        chk("rst_mid_idle", cpu_rdy, 1);

        // Non-trigger IDLE traffic
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            cpu_addr  = (i % 2 == 0) ? 16'h4015 : 16'h4014;
            cpu_rw    = (i % 2 == 0) ? 1'b0 : 1'b1;
            cpu_wdata = 8'(8'h10 + i);
            @(negedge clock);
            if (!cpu_rdy || dma_active) errs++;
            if ({bus_rw, bus_addr, bus_wdata} !== {cpu_rw, cpu_addr, cpu_wdata})
                errs++;
        end
        @(negedge clock);
        chk("idle_passthru", errs, 0);
        chk("idle_no_dma", cpu_rdy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
